// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, data-memory and write-back signal bundle for mem_access_unit
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_mem;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        req_regwrite;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        access_err;

  modport slave (
    input  req_valid, req_mem, req_write, req_size, req_unsigned,
           req_addr, req_wdata, req_rd, req_regwrite, mem_rdata,
    output stall, mem_addr, mem_wdata, mem_read, mem_write,
           wb_valid, wb_data, wb_rd, wb_regwrite, access_err
  );

  modport master (
    output req_valid, req_mem, req_write, req_size, req_unsigned,
           req_addr, req_wdata, req_rd, req_regwrite, mem_rdata,
    input  stall, mem_addr, mem_wdata, mem_read, mem_write,
           wb_valid, wb_data, wb_rd, wb_regwrite, access_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage controller: big-endian sub-word loads, RMW sub-word stores
module mem_access_unit #(
  parameter int unsigned DEPTH = 32
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_word_q, hold_word_d;
  logic [29:0] hold_idx_q, hold_idx_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        access_err_q, access_err_d;

  logic [29:0] word_idx;
  logic        is_byte, is_half, is_word;
  logic        misaligned, out_of_range;
  logic        accept, mem_op, err, ok_op;
  logic        do_load, do_wstore, do_sstore;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign word_idx     = bus.req_addr[31:2];
  assign is_byte      = (bus.req_size == 2'b00);
  assign is_half      = (bus.req_size == 2'b01);
  assign is_word      = bus.req_size[1];
  assign misaligned   = (is_half & bus.req_addr[0]) | (is_word & (bus.req_addr[1:0] != 2'b00));
  assign out_of_range = ({2'b00, word_idx} >= DEPTH_W);

  // Requests are only taken in IDLE; the held store is ignored during RMW_WR.
  assign accept    = (state_q == IDLE) & bus.req_valid & ~reset;
  assign mem_op    = accept & bus.req_mem;
  assign err       = mem_op & (misaligned | out_of_range);
  assign ok_op     = mem_op & ~err;
  assign do_load   = ok_op & ~bus.req_write;
  assign do_wstore = ok_op & bus.req_write & is_word;
  assign do_sstore = ok_op & bus.req_write & ~is_word;

  always_comb begin
    byte_lane = 8'h00;
    case (bus.req_addr[1:0])
      2'b00:   byte_lane = bus.mem_rdata[31:24];
      2'b01:   byte_lane = bus.mem_rdata[23:16];
      2'b10:   byte_lane = bus.mem_rdata[15:8];
      default: byte_lane = bus.mem_rdata[7:0];
    endcase
    half_lane = bus.req_addr[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];

    load_data = bus.mem_rdata;
    if (is_byte) begin
      load_data = bus.req_unsigned ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
    end else if (is_half) begin
      load_data = bus.req_unsigned ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
    end
  end

  always_comb begin
    merged = bus.mem_rdata;
    if (is_byte) begin
      case (bus.req_addr[1:0])
        2'b00:   merged[31:24] = bus.req_wdata[7:0];
        2'b01:   merged[23:16] = bus.req_wdata[7:0];
        2'b10:   merged[15:8]  = bus.req_wdata[7:0];
        default: merged[7:0]   = bus.req_wdata[7:0];
      endcase
    end else if (bus.req_addr[1]) begin
      merged[15:0] = bus.req_wdata[15:0];
    end else begin
      merged[31:16] = bus.req_wdata[15:0];
    end
  end

  assign bus.stall     = do_sstore;
  assign bus.mem_read  = do_load | do_sstore;
  assign bus.mem_write = ((state_q == RMW_WR) & ~reset) | do_wstore;
  assign bus.mem_addr  = (state_q == RMW_WR) ? {2'b00, hold_idx_q} : {2'b00, word_idx};
  assign bus.mem_wdata = (state_q == RMW_WR) ? hold_word_q : bus.req_wdata;

  always_comb begin
    state_d       = state_q;
    hold_word_d   = hold_word_q;
    hold_idx_d    = hold_idx_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    access_err_d  = 1'b0;

    if (state_q == RMW_WR) begin
      state_d    = IDLE;
      wb_valid_d = 1'b1;
      wb_data_d  = 32'h0;
    end else if (bus.req_valid) begin
      wb_rd_d = bus.req_rd;
      if (!bus.req_mem) begin
        wb_valid_d    = 1'b1;
        wb_regwrite_d = bus.req_regwrite;
        wb_data_d     = bus.req_addr;
      end else if (err) begin
        wb_valid_d   = 1'b1;
        wb_data_d    = 32'h0;
        access_err_d = 1'b1;
      end else if (!bus.req_write) begin
        wb_valid_d    = 1'b1;
        wb_regwrite_d = bus.req_regwrite;
        wb_data_d     = load_data;
      end else if (is_word) begin
        wb_valid_d = 1'b1;
        wb_data_d  = 32'h0;
      end else begin
        state_d     = RMW_WR;
        hold_word_d = merged;
        hold_idx_d  = word_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_word_q   <= 32'h0;
      hold_idx_q    <= 30'h0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_data_q     <= 32'h0;
      wb_rd_q       <= 5'h00;
      access_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_word_q   <= hold_word_d;
      hold_idx_q    <= hold_idx_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      access_err_q  <= access_err_d;
    end
  end

  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_regwrite = wb_regwrite_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.access_err  = access_err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller between the EX/MEM pipeline register and the word-wide, word-indexed data memory.
- Converts byte addresses to word indices and performs sign/zero-extended sub-word loads.
- Performs sub-word stores as a two-cycle read-modify-write, stalling the pipeline for the extra cycle.
- Registers the MEM/WB result (load data or pass-through ALU result) and flags misaligned or out-of-range accesses.

Parameters:
- DEPTH, 32, number of 32-bit words in data memory; valid word index 0..DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  EX/MEM slot holds a valid instruction.
- req_mem  input  1  1 = load/store; 0 = non-memory instruction, ALU result passes through.
- req_write  input  1  1 = store, 0 = load (meaningful only when req_mem=1).
- req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  input  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend.
- req_addr  input  32  byte address for memory ops; ALU result for non-memory ops.
- req_wdata  input  32  store data; the low byte or half is used for sub-word stores.
- req_rd  input  5  destination register.
- req_regwrite  input  1  instruction writes a register.
- stall  output  1  combinational; upstream must hold every req_* input for the next cycle.
- mem_addr  output  32  word index = req_addr >> 2.
- mem_wdata  output  32  word to write.
- mem_rdata  input  32  combinational read data from memory.
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe; level-sensitive at memory, high for exactly one cycle per store.
- wb_valid  output  1  registered; one completed instruction.
- wb_data  output  32  registered write-back data.
- wb_rd  output  5  registered destination register.
- wb_regwrite  output  1  registered register-write enable.
- access_err  output  1  registered one-cycle pulse on a misaligned or out-of-range access.

Behaviour:
- States: IDLE, RMW_WR.
- Reset value: all registered outputs 0; state = IDLE.
- While reset=1: stall, mem_read and mem_write are forced to 0.

Byte-lane mapping (big-endian):
- Byte: addr[1:0]=00 selects bits [31:24], 01 selects [23:16], 10 selects [15:8], 11 selects [7:0].
- Half: addr[1]=0 selects bits [31:16], addr[1]=1 selects [15:0].

Access errors (err):
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]≠0.
- Out of range: word index ≥ DEPTH.
- On err: no memory strobe, no stall; next cycle access_err=1, wb_valid=1, wb_regwrite=0, wb_data=0.

IDLE state, req_valid=1:
- Non-memory (req_mem=0): next cycle wb_data=req_addr, wb_regwrite=req_regwrite, wb_rd=req_rd, wb_valid=1. Latency 1.
- Load: mem_read=1 in this cycle. Next cycle wb_data = extracted lane, sign- or zero-extended to 32 bits; wb_regwrite=req_regwrite; wb_valid=1. Latency 1.
- Word store: mem_write=1, mem_wdata=req_wdata in this cycle. Next cycle wb_valid=1, wb_regwrite=0, wb_data=0.
- Byte/half store:
  - stall=1 and mem_read=1 in this cycle.
  - Latch merged word (mem_rdata with the target lane replaced by req_wdata[7:0] or [15:0]) and the word index into hold registers.
  - Go to RMW_WR. No wb_valid this cycle (next-cycle wb_valid=0).

IDLE state, req_valid=0:
- Next cycle wb_valid=0, wb_regwrite=0; wb_data and wb_rd hold their previous values.

RMW_WR state:
- mem_write=1, mem_addr and mem_wdata driven from the hold registers; stall=0.
- req_* inputs (still the held store) are ignored.
- Next cycle wb_valid=1, wb_regwrite=0. Return to IDLE.
- A new request is accepted only in the IDLE cycle that follows.

Reset and simultaneity:
- Reset asserted in RMW_WR: mem_write is suppressed that cycle, the store is dropped, state goes to IDLE, outputs return to 0.
- Memory strobes never assert together: mem_read and mem_write are mutually exclusive in every cycle.

Test Plan:
1. Memory word 3 = 0x80FF1234; lb addr 0x0C, then lbu addr 0x0C → wb_data 0xFFFFFF80, then 0x00000080. Each result arrives one cycle after the request; stall=0 throughout.
2. Word 5 = 0xAABBCCDD; sh addr 0x16, wdata 0x00001122:
   - Cycle 0: stall=1, mem_read=1.
   - Cycle 1: mem_write=1, mem_addr=5, mem_wdata=0xAABB1122.
   - Then lw addr 0x14 returns 0xAABB1122.
3. sb addr 0x09, wdata 0x000000EE onto word 2 = 0 → mem_wdata 0x00EE0000. Held request ignored in RMW_WR (exactly one mem_write pulse). wb_valid pulses once.
4. lw addr 0x02 and lh addr 0x05 → access_err pulses, wb_regwrite=0, no mem_read; addr 0x80 (index 32, DEPTH=32) also → access_err.
5. Reset asserted during RMW_WR → mem_write stays 0, word unchanged, all wb_* and access_err read 0 next cycle.
6. Non-memory op, req_addr 0x1234, rd 7, regwrite 1 → next cycle wb_data=0x1234, wb_rd=7, wb_regwrite=1; mem_read and mem_write stay 0.
